// File: rtl/dma_hold_arbiter.sv
// dma_hold_arbiter: CPU-side DMA hold controller.
// Picks one pending request channel, raises drq with its ID, waits for hrq,
// hands the bus over with start_transfer and takes it back on transfer_done.
// A watchdog abandons requests that never see hrq.
module dma_hold_arbiter #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] dma_req,
  output logic              drq,
  output logic [CH_W-1:0]   drq_ch,
  input  logic              hrq,
  output logic              start_transfer,
  input  logic              dack,
  input  logic              transfer_done,
  output logic [NUM_CH-1:0] grant,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);

  state_t              state_q;
  logic [CH_W-1:0]     sel_q;
  logic [CH_W-1:0]     sel_d;
  logic                sel_hit;
  logic [CH_W-1:0]     rr_ptr_q;
  logic [CH_W-1:0]     scan_base;
  logic [CH_W-1:0]     rr_ptr_d;
  logic [TO_W-1:0]     wdog_q;
  logic                drq_q;
  logic [CH_W-1:0]     drq_ch_q;
  logic                start_q;
  logic [NUM_CH-1:0]   grant_q;
  logic                busy_q;
  logic                timeout_err_q;

  // dack only reports transfer progress; holding the bus never depends on it.
  logic                unused_dack;
  assign unused_dack = dack;

  // Channel index 'off' positions above 'base', wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base,
                                                input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // Fixed priority is round-robin scanning from a pointer pinned at 0.
  assign scan_base = (RR_MODE != 0) ? rr_ptr_q : '0;

  // Pointer to the channel after the current grant, used whenever a grant ends.
  assign rr_ptr_d = (sel_q == CH_LAST) ? '0 : sel_q + 1'b1;

  // Arbiter: first pending request scanning upward from scan_base.
  always_comb begin
    sel_d   = '0;
    sel_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!sel_hit && dma_req[wrap_idx(scan_base, i)]) begin
        sel_d   = wrap_idx(scan_base, i);
        sel_hit = 1'b1;
      end
    end
  end

  // Hold-handshake FSM with registered outputs and the hrq watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      rr_ptr_q      <= '0;
      wdog_q        <= '0;
      drq_q         <= 1'b0;
      drq_ch_q      <= '0;
      start_q       <= 1'b0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|dma_req && !transfer_done) begin
            sel_q    <= sel_d;
            drq_q    <= 1'b1;
            drq_ch_q <= sel_d;
            busy_q   <= 1'b1;
            wdog_q   <= '0;
            state_q  <= HOLD_REQ;
          end else begin
            drq_q <= 1'b0;
          end
        end
        HOLD_REQ: begin
          // hrq takes precedence over a watchdog expiring on the same edge.
          if (hrq) begin
            start_q <= 1'b1;
            grant_q <= NUM_CH'(1) << sel_q;
            state_q <= HOLD;
          end else if (wdog_q == WDOG_LAST) begin
            drq_q         <= 1'b0;
            timeout_err_q <= 1'b1;
            rr_ptr_q      <= rr_ptr_d;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        HOLD: begin
          if (transfer_done) begin
            drq_q    <= 1'b0;
            start_q  <= 1'b0;
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= RELEASE;
          end
        end
        RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drq            = drq_q;
  assign drq_ch         = drq_ch_q;
  assign start_transfer = start_q;
  assign grant          = grant_q;
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_dma_hold_arbiter.sv
// Directed bench for dma_hold_arbiter: one round-robin and one fixed-priority instance.
module tb_dma_hold_arbiter;

  logic       clk = 1'b0;
  logic       rst;

  logic [3:0] dma_req;
  logic       hrq, dack, transfer_done;
  logic       drq, start_transfer, busy, timeout_err;
  logic [1:0] drq_ch;
  logic [3:0] grant;

  logic [3:0] dma_req_f;
  logic       hrq_f, transfer_done_f;
  logic       drq_f, start_transfer_f, busy_f, timeout_err_f;
  logic [1:0] drq_ch_f;
  logic [3:0] grant_f;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dma_hold_arbiter #(.NUM_CH(4), .CH_W(2), .RR_MODE(1), .TIMEOUT(255), .TO_W(8)) dut_rr (
    .clk(clk), .rst(rst), .dma_req(dma_req), .drq(drq), .drq_ch(drq_ch),
    .hrq(hrq), .start_transfer(start_transfer), .dack(dack),
    .transfer_done(transfer_done), .grant(grant), .busy(busy),
    .timeout_err(timeout_err)
  );

  dma_hold_arbiter #(.NUM_CH(4), .CH_W(2), .RR_MODE(0), .TIMEOUT(255), .TO_W(8)) dut_fp (
    .clk(clk), .rst(rst), .dma_req(dma_req_f), .drq(drq_f), .drq_ch(drq_ch_f),
    .hrq(hrq_f), .start_transfer(start_transfer_f), .dack(dack),
    .transfer_done(transfer_done_f), .grant(grant_f), .busy(busy_f),
    .timeout_err(timeout_err_f)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for drq on the round-robin DUT, then run one full hold handshake.
  task automatic grant_rr(input string tag, input logic [1:0] exp_ch);
    int waited = 0;
    while (!drq && waited < 10) begin
      tick();
      waited++;
    end
    check({tag, "_wait"}, waited, 1);
    check({tag, "_ch"}, drq_ch, exp_ch);
    hrq = 1'b1;
    tick();
    hrq = 1'b0;
    check({tag, "_grant"}, grant, 4'b0001 << exp_ch);
    transfer_done = 1'b1;
    tick();
    transfer_done = 1'b0;
    check({tag, "_rel"}, {drq, start_transfer, busy}, 3'b001);
    tick();
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic grant_fp(input string tag, input logic [1:0] exp_ch);
    int waited = 0;
    while (!drq_f && waited < 10) begin
      tick();
      waited++;
    end
    check({tag, "_wait"}, waited, 1);
    check({tag, "_ch"}, drq_ch_f, exp_ch);
    hrq_f = 1'b1;
    tick();
    hrq_f = 1'b0;
    check({tag, "_grant"}, grant_f, 4'b0001 << exp_ch);
    transfer_done_f = 1'b1;
    tick();
    transfer_done_f = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; dma_req = '0; hrq = 0; dack = 0; transfer_done = 0;
    dma_req_f = '0; hrq_f = 0; transfer_done_f = 0;
    do_reset();

    // Reset state
    check("rst_outs", {drq, drq_ch, start_transfer, grant, busy, timeout_err}, 10'h0);
    check("rst_outs_fp", {drq_f, start_transfer_f, grant_f, busy_f}, 7'h0);

    // T3: fixed priority, 1010 held -> always channel 1
    dma_req_f = 4'b1010;
    for (int i = 0; i < 3; i++) grant_fp($sformatf("t3_g%0d", i), 2'd1);
    dma_req_f = '0;

    // T1: single request on channel 2
    dma_req = 4'b0100;
    tick();
    check("t1_drq", {drq, drq_ch, busy, start_transfer}, 5'b1_10_1_0);
    dma_req = 4'b0000;
    hrq = 1'b1; dack = 1'b1;
    tick();
    hrq = 1'b0;
    check("t1_start", {start_transfer, grant}, 5'b1_0100);
    tick();
    check("t1_hold", {start_transfer, drq}, 2'b11);
    transfer_done = 1'b1;
    tick();
    transfer_done = 1'b0; dack = 1'b0;
    check("t1_done", {drq, start_transfer, grant, busy}, 7'b0_0_0000_1);
    tick();
    check("t1_busy", busy, 0);

    // T2: round-robin fairness with all channels requesting
    do_reset();
    dma_req = 4'b1111;
    grant_rr("t2_g0", 2'd0);
    grant_rr("t2_g1", 2'd1);
    grant_rr("t2_g2", 2'd2);
    grant_rr("t2_g3", 2'd3);
    grant_rr("t2_g4", 2'd0);
    dma_req = '0;

    // T4: watchdog abort after 255 cycles in HOLD_REQ
    do_reset();
    dma_req = 4'b0010;
    tick();
    check("t4_drq", {drq, drq_ch}, 3'b1_01);
    dma_req = '0;
    repeat (254) tick();
    check("t4_pre", {drq, timeout_err, busy}, 3'b101);
    tick();
    check("t4_abort", {drq, timeout_err, busy}, 3'b010);
    tick();
    check("t4_pulse", timeout_err, 0);
    dma_req = 4'b1111;
    tick();
    check("t4_rearb", {drq, drq_ch}, 3'b1_10);

    // T5: transfer_done ignored in HOLD_REQ; hrq on the expiry edge wins
    transfer_done = 1'b1;
    tick();
    transfer_done = 1'b0;
    check("t5_td_ign", {drq, start_transfer, busy}, 3'b101);
    repeat (253) tick();
    check("t5_pre", {drq, timeout_err}, 2'b10);
    hrq = 1'b1;
    tick();
    hrq = 1'b0;
    check("t5_hold", {start_transfer, timeout_err, grant}, 6'b1_0_0100);

    // T6: reset in HOLD clears everything and the round-robin pointer
    rst = 1'b1;
    tick();
    check("t6_rst", {drq, drq_ch, start_transfer, grant, busy, timeout_err}, 10'h0);
    rst = 1'b0;
    tick();
    check("t6_rearb", {drq, drq_ch}, 3'b1_00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
